vdp18_vram_arb: RTL

CPU/video VRAM arbiter for the vdp18 TMS9918A core. Sits between the timing controller, the video address generator, the CPU port and the external 16K×8 VRAM. Holds one pending CPU read or write. Issues it only in a free access slot, meaning a slot the timing controller marks as CPU-owned. Returns read data with a valid strobe. Video fetches always own their slots.

---
 rtl/vdp18_vram_arb.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/vdp18_vram_arb.sv
// vdp18_vram_arb: CPU/video VRAM access arbiter for the vdp18 core.
// Holds one pending CPU access and issues it only in a CPU-owned slot;
// video fetches otherwise drive the VRAM address every cycle.
// Optional build macro: VDP18_ARB_BLANK_FAST_EN lets every pixel-rate
// enable during vertical blank act as a CPU slot.

package vdp18_vram_arb_pkg;
    typedef enum logic [3:0] {
        AC_NONE = 4'd0,
        AC_PNT  = 4'd1,
        AC_PGT  = 4'd2,
        AC_PCT  = 4'd3,
        AC_STST = 4'd4,
        AC_SATY = 4'd5,
        AC_SATX = 4'd6,
        AC_SATN = 4'd7,
        AC_SATC = 4'd8,
        AC_SPTH = 4'd9,
        AC_SPTL = 4'd10,
        AC_CPU  = 4'd11
    } access_t;
endpackage

// state   | meaning
// IDLE    | no CPU access held; video owns the address bus
// PEND    | CPU access held, waiting for a CPU slot
// RD_WAIT | read address on the bus, capturing RAM data this cycle
module vdp18_vram_arb
    import vdp18_vram_arb_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clk_en_5m37_i,
    input  logic              clk_en_acc_i,
    input  access_t           access_type_i,
    input  logic              vert_active_i,
    input  logic [ADDR_W-1:0] vid_addr_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [7:0]        cpu_wdata_i,
    output logic              cpu_busy_o,
    output logic [7:0]        cpu_rdata_o,
    output logic              cpu_rvalid_o,
    output logic              cpu_ovr_o,
    output logic [ADDR_W-1:0] vram_a_o,
    output logic [7:0]        vram_d_o,
    output logic              vram_we_o,
    input  logic [7:0]        vram_d_i
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PEND    = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;

`ifdef VDP18_ARB_BLANK_FAST_EN
    localparam logic BLANK_FAST = 1'b1;
`else
    localparam logic BLANK_FAST = 1'b0;
`endif

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic              hold_we_q, hold_we_d;
    logic [7:0]        hold_wdata_q, hold_wdata_d;
    logic [ADDR_W-1:0] vram_a_q, vram_a_d;
    logic [7:0]        vram_d_q, vram_d_d;
    logic              vram_we_q, vram_we_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              busy_q, busy_d;
    logic              ovr_q, ovr_d;
    logic              acc_slot, blank_slot, cpu_slot;

    // A slot is granted to the CPU when the controller marks it CPU-owned,
    // or (fast-blank build only) on any pixel enable during vertical blank.
    always_comb begin
        acc_slot   = clk_en_acc_i & clk_en_5m37_i & (access_type_i == AC_CPU);
        blank_slot = clk_en_5m37_i & ~vert_active_i;
        cpu_slot   = acc_slot | (BLANK_FAST & blank_slot);
    end

    // Next-state and output computation; busy also covers the write-issue
    // cycle so a request arriving then is dropped like any other overrun.
    always_comb begin
        state_d      = state_q;
        hold_addr_d  = hold_addr_q;
        hold_we_d    = hold_we_q;
        hold_wdata_d = hold_wdata_q;
        vram_a_d     = vid_addr_i;
        vram_d_d     = vram_d_q;
        vram_we_d    = 1'b0;
        rdata_d      = rdata_q;
        rvalid_d     = 1'b0;
        ovr_d        = ovr_q | (cpu_req_i & busy_q);

        case (state_q)
            ST_IDLE: begin
                if (cpu_req_i && !busy_q) begin
                    hold_addr_d  = cpu_addr_i;
                    hold_we_d    = cpu_we_i;
                    hold_wdata_d = cpu_wdata_i;
                    state_d      = ST_PEND;
                end
            end
            ST_PEND: begin
                if (cpu_slot) begin
                    vram_a_d = hold_addr_q;
                    if (hold_we_q) begin
                        vram_d_d  = hold_wdata_q;
                        vram_we_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                rdata_d  = vram_d_i;
                rvalid_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE) | vram_we_d;
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            hold_addr_q  <= '0;
            hold_we_q    <= 1'b0;
            hold_wdata_q <= '0;
            vram_a_q     <= '0;
            vram_d_q     <= '0;
            vram_we_q    <= 1'b0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            busy_q       <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_addr_q  <= hold_addr_d;
            hold_we_q    <= hold_we_d;
            hold_wdata_q <= hold_wdata_d;
            vram_a_q     <= vram_a_d;
            vram_d_q     <= vram_d_d;
            vram_we_q    <= vram_we_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            busy_q       <= busy_d;
            ovr_q        <= ovr_d;
        end
    end

    assign cpu_busy_o   = busy_q;
    assign cpu_rdata_o  = rdata_q;
    assign cpu_rvalid_o = rvalid_q;
    assign cpu_ovr_o    = ovr_q;
    assign vram_a_o     = vram_a_q;
    assign vram_d_o     = vram_d_q;
    assign vram_we_o    = vram_we_q;

endmodule
